hazard_stall_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) stall-based core without forwarding. It sits beside the instruction decoder and consumes the decoded control bits of the instruction in ID. It keeps its own shadow copy of the EX/MEM/WB occupancy, plus the CMP condition flags. It drives PC/IF-ID write enables, ID/EX bubble insertion, branch redirect and flush, and two performance counters.

---
 rtl/hazard_stall_ctrl_if.sv | 43 ++++
 rtl/hazard_stall_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Decoder-side bundle for the hazard/sequencing controller: decoded ID
// instruction fields and EX ALU flags in, pipeline control and counters out.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_cmp;
  logic                  id_branch;
  logic                  id_bge;
  logic                  id_ble;
  logic                  ex_alu_n;
  logic                  ex_alu_z;

  logic                  pc_write_en;
  logic                  ifid_write_en;
  logic                  idex_bubble;
  logic                  ifid_flush;
  logic                  branch_taken;
  logic                  flag_n;
  logic                  flag_z;
  logic [15:0]           stall_count;
  logic [15:0]           flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_cmp, id_branch, id_bge, id_ble, ex_alu_n, ex_alu_z,
    input  pc_write_en, ifid_write_en, idex_bubble, ifid_flush, branch_taken,
           flag_n, flag_z, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_cmp, id_branch, id_bge, id_ble, ex_alu_n, ex_alu_z,
    output pc_write_en, ifid_write_en, idex_bubble, ifid_flush, branch_taken,
           flag_n, flag_z, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for a 5-stage core without forwarding: tracks a shadow
// EX/MEM/WB occupancy, resolves branches in EX and counts stall/flush cycles.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int WB_BYPASS  = 0
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave ctrl
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  cmp;
    logic                  branch;
    logic                  bge;
    logic                  ble;
  } stage_t;

  stage_t ex_q, mem_q, wb_q, ex_d;
  logic   flag_n_q, flag_n_d, flag_z_q, flag_z_d;
  logic   raw_rs1, raw_rs2, wb_hit_rs1, wb_hit_rs2;
  logic   taken, flush, stall;
  logic [1:0] cnt_event;

  function automatic logic producer_hit(stage_t s, logic [REG_ADDR_W-1:0] rs);
    return s.valid & s.reg_write & (s.rd == rs);
  endfunction

  // With a write-before-read register file the WB producer is already visible.
  assign wb_hit_rs1 = (WB_BYPASS == 0) && producer_hit(wb_q, ctrl.id_rs1);
  assign wb_hit_rs2 = (WB_BYPASS == 0) && producer_hit(wb_q, ctrl.id_rs2);

  assign raw_rs1 = ctrl.id_use_rs1 &
                   (producer_hit(ex_q, ctrl.id_rs1) | producer_hit(mem_q, ctrl.id_rs1) | wb_hit_rs1);
  assign raw_rs2 = ctrl.id_use_rs2 &
                   (producer_hit(ex_q, ctrl.id_rs2) | producer_hit(mem_q, ctrl.id_rs2) | wb_hit_rs2);

  assign taken = ex_q.valid &
                 (ex_q.branch | (ex_q.bge & ~flag_n_q) | (ex_q.ble & (flag_n_q | flag_z_q)));
  assign flush = taken;
  // A taken branch squashes the ID instruction, so its hazard is moot.
  assign stall = ctrl.id_valid & (raw_rs1 | raw_rs2) & ~flush;

  assign ctrl.pc_write_en   = ~stall | flush;
  assign ctrl.ifid_write_en = ~stall | flush;
  assign ctrl.idex_bubble   = stall | flush;
  assign ctrl.ifid_flush    = flush;
  assign ctrl.branch_taken  = taken;
  assign ctrl.flag_n        = flag_n_q;
  assign ctrl.flag_z        = flag_z_q;

  always_comb begin
    ex_d = '0;
    if (ctrl.id_valid && !stall && !flush) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = ctrl.id_rd;
      ex_d.reg_write = ctrl.id_reg_write;
      ex_d.cmp       = ctrl.id_cmp;
      ex_d.branch    = ctrl.id_branch;
      ex_d.bge       = ctrl.id_bge;
      ex_d.ble       = ctrl.id_ble;
    end
  end

  always_comb begin
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    if (ex_q.valid && ex_q.cmp) begin
      flag_n_d = ctrl.ex_alu_n;
      flag_z_d = ctrl.ex_alu_z;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  // Index 0 counts stall cycles, index 1 counts flush cycles; both saturate.
  assign cnt_event = {flush, stall};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (cnt_event[gi] && (cnt_q != 16'hFFFF)) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  endgenerate

  assign ctrl.stall_count = g_cnt[0].cnt_q;
  assign ctrl.flush_count = g_cnt[1].cnt_q;

  // Control bits past EX only ride along the shadow pipeline.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{mem_q.cmp, mem_q.branch, mem_q.bge, mem_q.ble,
                               wb_q.cmp, wb_q.branch, wb_q.bge, wb_q.ble};

endmodule
